// File: rtl/sram_wb_pkg.sv
// sram_wb_pkg: shared constants for the SRAM wishbone responder
// Holds the FSM state encoding and the SRAM address, data and wait-counter widths.
package sram_wb_pkg;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_ACK      = 3'd5;
    localparam logic [2:0] S_TURN     = 3'd6;
endpackage

// File: rtl/sram_byte_merge.sv
// sram_byte_merge: per-lane select between an old and a new 32-bit word
// i_old: word read back from SRAM, i_new: wishbone write data,
// i_sel: byte lanes taken from i_new, o_merged: resulting word.
module sram_byte_merge
    import sram_wb_pkg::*;
(
    input  logic [DW-1:0] i_old,
    input  logic [DW-1:0] i_new,
    input  logic [3:0]    i_sel,
    output logic [DW-1:0] o_merged
);
    for (genvar b = 0; b < 4; b++) begin : g_lane
        assign o_merged[8*b+:8] = i_sel[b] ? i_new[8*b+:8] : i_old[8*b+:8];
    end
endmodule

// File: rtl/sram_wb_slave.sv
// sram_wb_slave: wishbone responder driving one 32-bit asynchronous SRAM bank
// Ports: clk/rst (sync, active-high); wb_* single-word wishbone slave with
// registered ack and read data; ram_* SRAM address, tri-state data bus and
// active-low ce/oe/we. Partial-word writes run as read-modify-write.
module sram_wb_slave
    import sram_wb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [31:0]   wb_addr_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [DW-1:0] wb_data_i,
    output logic [DW-1:0] wb_data_o,
    output logic          wb_ack_o,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data,
    output logic          ram_ce,
    output logic          ram_oe,
    output logic          ram_we
);
    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [3:0]    r_sel;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_wbuf;
    logic [DW-1:0] r_dout;
    logic [AW-1:0] r_addr;
    logic          r_ack;
    logic [DW-1:0] w_merged;
    logic          w_req;
    logic          w_last;
    logic          w_drive;
    logic          w_unused;
    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_last   = r_cnt == '0;
    assign w_drive  = r_state == S_WR_SETUP || r_state == S_WR_PULSE || r_state == S_WR_HOLD;
    assign w_unused = ^{wb_addr_i[31:22], wb_addr_i[1:0]};
    sram_byte_merge u_merge (
        .i_old    (ram_data),
        .i_new    (r_wdata),
        .i_sel    (r_sel),
        .o_merged (w_merged)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_req) w_next = !wb_we_i ? S_RD : wb_sel_i == 4'hF ? S_WR_SETUP :
                                            wb_sel_i == 4'h0 ? S_ACK : S_RD;
            S_RD:       if (w_last) w_next = r_we ? S_WR_SETUP : S_ACK;
            S_WR_SETUP: w_next = S_WR_PULSE;
            S_WR_PULSE: if (w_last) w_next = S_WR_HOLD;
            S_WR_HOLD:  w_next = S_ACK;
            S_ACK:      w_next = S_TURN;
            default:    w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_wdata <= '0;
            r_wbuf  <= '0;
            r_dout  <= '0;
            r_addr  <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_next == S_ACK;
            // counter idles at WAIT_CYCLES-1 so each RD/WR_PULSE entry starts a full count
            r_cnt   <= ((r_state == S_RD || r_state == S_WR_PULSE) && !w_last) ? r_cnt - 1'b1
                                                                                : CW'(WAIT_CYCLES - 1);
            if (r_state == S_IDLE && w_req) begin
                r_addr  <= wb_addr_i[21:2];
                r_we    <= wb_we_i;
                r_sel   <= wb_sel_i;
                r_wdata <= wb_data_i;
                r_wbuf  <= wb_data_i;
            end
            // old lanes come straight off the bus at the capture edge
            if (r_state == S_RD && w_last) begin
                r_wbuf <= w_merged;
                if (!r_we) r_dout <= ram_data;
            end
        end
    end
    assign wb_ack_o  = r_ack;
    assign wb_data_o = r_dout;
    assign ram_addr  = r_addr;
    assign ram_ce    = !(r_state == S_RD || w_drive);
    assign ram_oe    = r_state != S_RD;
    assign ram_we    = r_state != S_WR_PULSE;
    assign ram_data  = w_drive ? r_wbuf : {DW{1'bz}};
endmodule

// File: tb/tb_sram_wb_slave.sv
// tb_sram_wb_slave: randomized self-checking bench with an SRAM model and reference memory
module tb_sram_wb_slave;
    localparam int W = 2;
    logic        clk = 0;
    logic        rst = 1;
    logic        cyc = 0, stb = 0, wen = 0;
    logic [31:0] addr = 0, din = 0;
    logic [3:0]  sel = 0;
    logic [31:0] dout;
    logic        ack;
    logic [19:0] ram_addr;
    wire  [31:0] ram_data;
    logic        ce, oe, rwe;
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    int          total = 0, bad = 0, we_lo = 0, ce_lo = 0;
    logic        drv_prev = 0, we_prev = 0;
    logic [19:0] addr_prev = 0;
    logic [31:0] data_prev = 0;
    always #5 clk = ~clk;
    sram_wb_slave #(.WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (wen),
        .wb_addr_i (addr),
        .wb_sel_i  (sel),
        .wb_data_i (din),
        .wb_data_o (dout),
        .wb_ack_o  (ack),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_ce    (ce),
        .ram_oe    (oe),
        .ram_we    (rwe)
    );
    assign ram_data = (!ce && !oe) ? mem[ram_addr[9:0]] : 32'hzzzzzzzz;
    always @(posedge clk) if (!ce && !rwe) mem[ram_addr[9:0]] <= ram_data;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) begin
        chk("oe_we_overlap", {31'd0, !oe && !rwe}, 0);
        chk("bus_driven_while_ce_high", {31'd0, ce && (ram_data !== 32'hzzzzzzzz)}, 0);
        if (!rwe) chk("we_low_without_prior_drive", {31'd0, drv_prev}, 1);
        if (!rwe && we_prev) begin
            chk("addr_stable_in_pulse", {12'd0, ram_addr}, {12'd0, addr_prev});
            chk("data_stable_in_pulse", ram_data, data_prev);
        end
        drv_prev  <= oe && (ram_data !== 32'hzzzzzzzz);
        we_prev   <= !rwe;
        addr_prev <= ram_addr;
        data_prev <= ram_data;
        we_lo += int'(!rwe);
        ce_lo += int'(!ce);
    end
    task automatic wait_ack(inout int n);
        while (!ack && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
    endtask
    task automatic req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int n, exp_n, exp_ce;
        logic [9:0]  idx;
        logic [31:0] old;
        idx    = a[11:2];
        old    = ref_mem[idx];
        exp_n  = !w ? W + 1 : s == 4'hF ? W + 3 : s == 4'h0 ? 1 : 2 * W + 3;
        exp_ce = !w ? W : s == 4'hF ? W + 2 : s == 4'h0 ? 0 : 2 * W + 2;
        cyc = 1; stb = 1; wen = w; addr = a; sel = s; din = d;
        we_lo = 0; ce_lo = 0;
        @(posedge clk); #1;
        chk("ram_addr", {12'd0, ram_addr}, {22'd0, idx});
        stb = 0; cyc = 1'($urandom); wen = 1'($urandom); addr = $urandom; sel = 4'($urandom); din = $urandom;
        n = 1;
        wait_ack(n);
        chk("ack_latency", n, exp_n);
        if (!w) chk("read_data", dout, old);
        else for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b+:8] = d[8*b+:8];
        @(posedge clk); #1;
        chk("ack_one_cycle", {31'd0, ack}, 0);
        chk("we_pulse_cycles", we_lo, (w && s != 4'h0) ? W : 0);
        chk("ce_low_cycles", ce_lo, exp_ce);
        chk("mem_word", mem[idx], ref_mem[idx]);
        cyc = 0;
        @(posedge clk); #1;
    endtask
    initial begin
        int n;
        logic [31:0] a;
        logic [3:0]  s;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce", {31'd0, ce}, 1);
        chk("rst_oe", {31'd0, oe}, 1);
        chk("rst_we", {31'd0, rwe}, 1);
        chk("rst_ack", {31'd0, ack}, 0);
        chk("rst_bus_z", {31'd0, ram_data === 32'hzzzzzzzz}, 1);
        chk("rst_dout", dout, 0);
        chk("rst_addr", {12'd0, ram_addr}, 0);
        rst = 0;
        @(posedge clk); #1;
        req(0, 32'h0000_0010, 4'hF, 32'h0);
        chk("read_deadbeef", dout, 32'hDEADBEEF);
        req(1, 32'h0000_0020, 4'hF, 32'h12345678);
        chk("full_write_word", mem[8], 32'h12345678);
        req(1, 32'h0000_0020, 4'b0101, 32'hAABBCCDD);
        chk("partial_write_word", mem[8], 32'h12BB56DD);
        req(1, 32'h0000_0020, 4'h0, 32'hFFFFFFFF);
        chk("sel0_write_word", mem[8], 32'h12BB56DD);
        cyc = 1; stb = 1; wen = 1; addr = 32'h40; sel = 4'hF; din = 32'hCAFEF00D;
        @(posedge clk); #1;
        n = 1;
        wait_ack(n);
        chk("b2b_first_ack", n, W + 3);
        ref_mem[16] = 32'hCAFEF00D;
        wen = 0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ce && n < 16);
        chk("b2b_gap", n, 3);
        stb = 0; cyc = 0;
        n = 1;
        wait_ack(n);
        chk("b2b_second_ack", n, W + 1);
        chk("b2b_read_data", dout, 32'hCAFEF00D);
        repeat (2) begin @(posedge clk); #1; end
        cyc = 1; stb = 1; wen = 1; addr = 32'h80; sel = 4'hF; din = 32'h0BADF00D;
        @(posedge clk); #1;
        stb = 0; cyc = 0;
        @(posedge clk); #1;
        chk("pulse_before_rst", {31'd0, rwe}, 0);
        rst = 1;
        @(posedge clk); #1;
        chk("midrst_we", {31'd0, rwe}, 1);
        chk("midrst_ce", {31'd0, ce}, 1);
        chk("midrst_bus_z", {31'd0, ram_data === 32'hzzzzzzzz}, 1);
        chk("midrst_ack", {31'd0, ack}, 0);
        chk("midrst_dout", dout, 0);
        rst = 0;
        ref_mem[32] = mem[32];
        @(posedge clk); #1;
        req(0, 32'h0000_0010, 4'hF, 32'h0);
        chk("post_rst_read", dout, 32'hDEADBEEF);
        for (int k = 0; k < 60; k++) begin
            a = $urandom & 32'hFFC0_0FFF;
            case ($urandom_range(0, 3))
                0:       s = 4'hF;
                1:       s = 4'h0;
                default: s = 4'($urandom);
            endcase
            req(1'($urandom), a, s, $urandom);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_wb_slave.md
# sram_wb_slave

Wishbone responder for one 32-bit asynchronous SRAM bank (base or ext RAM), sitting behind the bus decoder on the CPU's wishbone master port. Turns single-word requests into timed SRAM read/write cycles with configurable wait states. Returns one registered acknowledge per request. The SRAM has no byte enables, so partial-word writes are done internally as read-modify-write.

## Interface
- WAIT_CYCLES, 2: SRAM access cycles per read or write pulse (1..15).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe; a request is `cyc & stb`.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_addr_i  in  32  byte address; only [21:2] used.
- wb_sel_i  in  4  byte lanes; bit n selects data[8n+7:8n].
- wb_data_i  in  32  write data.
- wb_data_o  out  32  read data, registered; valid while wb_ack_o=1.
- wb_ack_o  out  1  one-cycle acknowledge, registered.
- ram_addr  out  20  SRAM word address.
- ram_data  inout  32  SRAM data bus; tri-stated unless writing.
- ram_ce  out  1  chip enable, active-low.
- ram_oe  out  1  output enable, active-low.
- ram_we  out  1  write enable, active-low.

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK, TURN.
- IDLE: a request is accepted at the clock edge where it is seen.
  - ram_addr is latched from wb_addr_i[21:2].
  - Read, or write with sel≠4'b1111 and sel≠0: go to RD.
  - Write with sel=4'b1111: go to WR_SETUP.
  - Write with sel=0: go straight to ACK with no SRAM access.
- RD: ce=0, oe=0, we=1. Stays WAIT_CYCLES cycles on a down-counter.
  - At the edge ending the last RD cycle, ram_data is captured into a read register.
  - Read: go to ACK.
  - Partial write: merge into the write buffer (selected lanes from wb_data_i, others from the read register), then go to WR_SETUP.
- WR_SETUP: 1 cycle; ce=0, oe=1, we=1, ram_data driven from the write buffer.
- WR_PULSE: WAIT_CYCLES cycles; we=0, data still driven.
- WR_HOLD: 1 cycle; we=1, ce=0, data still driven. Go to ACK.
- ACK: wb_ack_o=1 for exactly one cycle.
  - wb_data_o = read register for reads; unchanged for writes.
  - SRAM controls are all high.
- TURN: 1 cycle; requests are ignored (bus turnaround plus the master's registered stb drop). Go to IDLE.
- ram_data is high-Z in every state except WR_SETUP, WR_PULSE and WR_HOLD.
- Input latching:
  - wb_we_i, wb_sel_i, wb_data_i and the address are latched at acceptance.
  - Later changes on the wishbone inputs are ignored until TURN.
  - Dropping stb mid-access does not abort the access.
- Reset, including mid-access: next edge gives IDLE, ram_ce/oe/we=1, ram_data high-Z, wb_ack_o=0, wb_data_o=0, ram_addr=0, counter=0. A write interrupted by reset may leave SRAM contents undefined.

## Timing
- Acceptance edge is t0. wb_ack_o is high during cycle:
  - read: t0+WAIT_CYCLES+1
  - full write: t0+WAIT_CYCLES+3
  - partial write: t0+2·WAIT_CYCLES+3
  - sel=0 write: t0+1
- Earliest next acceptance is 2 cycles after the ack cycle (ACK, then TURN).
- ram_we never falls in the same cycle ram_data first drives, and never rises in the last cycle ram_data is driven. Address and data are stable for the whole low pulse.
- oe and we are never low in the same cycle.

## Structure
- Package sram_wb_pkg holds:
  - state encoding (3-bit localparams)
  - SRAM address width (20) and data width (32)
  - counter width (4)
- Sub-module sram_byte_merge: combinational, takes (old[31:0], new[31:0], sel[3:0]) and gives merged[31:0]. Used for the RMW path.
- The top holds the FSM, wait counter, latched request, read register, write buffer and tri-state control.

## Test plan
- Reset with WAIT_CYCLES=2: all controls 1, ram_data Z, ack 0. Read addr 0x00000010 with SRAM model word 4 = 0xDEADBEEF → ram_addr=4, ack at t0+3, wb_data_o=0xDEADBEEF.
- Full write 0x12345678 to 0x00000020, sel=4'hF → one we low pulse of 2 cycles with ram_addr=8, ack at t0+5; model word 8 = 0x12345678.
- Partial write: word 8 = 0x12345678, write 0xAABBCCDD with sel=4'b0101 → RD then write, ack at t0+7; word 8 = 0x12BB56DD.
- Write with sel=0 → ack at t0+1, no ce/we activity, SRAM unchanged.
- Back-to-back requests with stb held high → second acceptance exactly 2 cycles after the first ack. The bench checks oe/we never both low, and that ram_data is driven only during write states.
- Assert rst during WR_PULSE → next edge: we=1, ce=1, ram_data Z, no ack. A following read completes normally.
